// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and sizing helpers for the parametrised
// synchronous FIFO family.
//   DWIDTH_DEF / DEPTH_DEF : default data width and entry count
//   clog2()                : ceiling log2, used to size pointers
//   cnt_width()            : occupancy counter width (pointer width + 1)
package fifo_pkg;

   localparam int DWIDTH_DEF = 32'sd32;
   localparam int DEPTH_DEF  = 32'sd16;

   // Ceiling log2 of a positive value; clog2(1) = 0.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 32'sd0;
      v   = value - 32'sd1;
      while (v > 32'sd0) begin
         res = res + 32'sd1;
         v   = v >>> 1;
      end
      return res;
   endfunction

   // The count must represent 0..DEPTH inclusive, hence one extra bit.
   function automatic int cnt_width(input int depth);
      return clog2(depth) + 32'sd1;
   endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// fifo_ram_dp: storage array for fifo_sync_param. No reset, no control.
//   Clk    : write clock, rising edge
//   WeN    : active-low write enable
//   WrAddr : write address
//   WrData : write data
//   RdAddr : asynchronous read address
//   RdData : asynchronous read data (mem[RdAddr])
module fifo_ram_dp
   import fifo_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                      Clk,
   input  logic                      WeN,
   input  logic [clog2(DEPTH)-1:0]   WrAddr,
   input  logic [DWIDTH-1:0]         WrData,
   input  logic [clog2(DEPTH)-1:0]   RdAddr,
   output logic [DWIDTH-1:0]         RdData
);

   logic [DWIDTH-1:0] mem_q [DEPTH];

   // Synchronous write port; contents deliberately left unreset.
   always_ff @(posedge Clk) begin
      if (!WeN) begin
         mem_q[WrAddr] <= WrData;
      end
   end

   assign RdData = mem_q[RdAddr];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty, sticky error flags and a
// selectable show-ahead (FWFT=1) or registered-read (FWFT=0) output.
//   Clk, RstN          : clock and async active-low reset
//   ClrN               : synchronous active-low clear (overrides WrN/RdN)
//   WrN, Data_In       : active-low write request and data
//   RdN                : active-low read request
//   AFullThr/AEmptyThr : almost-full / almost-empty thresholds
//   Data_Out           : read data
//   Count              : occupancy 0..DEPTH
//   FullN/EmptyN/AFullN/AEmptyN : registered active-low status flags
//   Ovf/Udf            : sticky overflow/underflow, active high
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int AWIDTH = clog2(DEPTH),
   parameter bit FWFT   = 1'b1
) (
   input  logic              Clk,
   input  logic              RstN,
   input  logic              ClrN,
   input  logic              WrN,
   input  logic [DWIDTH-1:0] Data_In,
   input  logic              RdN,
   input  logic [AWIDTH:0]   AFullThr,
   input  logic [AWIDTH:0]   AEmptyThr,
   output logic [DWIDTH-1:0] Data_Out,
   output logic [AWIDTH:0]   Count,
   output logic              FullN,
   output logic              EmptyN,
   output logic              AFullN,
   output logic              AEmptyN,
   output logic              Ovf,
   output logic              Udf
);

   localparam int CW = cnt_width(DEPTH);
   localparam logic [CW-1:0]     DEPTH_C = DEPTH[CW-1:0];
   localparam logic [CW-1:0]     CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_n_q, full_n_d;
   logic              empty_n_q, empty_n_d;
   logic              afull_n_q, afull_n_d;
   logic              aempty_n_q, aempty_n_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic [DWIDTH-1:0] dout_q, dout_d;

   logic              rd_acc_s;
   logic              wr_acc_s;
   logic              ram_we_n_s;
   logic [DWIDTH-1:0] ram_rd_s;

   // A write into a full FIFO is still accepted when a read frees a slot.
   assign rd_acc_s   = ~RdN & (count_q != {CW{1'b0}});
   assign wr_acc_s   = ~WrN & ((count_q != DEPTH_C) | rd_acc_s);
   assign ram_we_n_s = ~(wr_acc_s & ClrN);

   fifo_ram_dp #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_ram (
      .Clk    (Clk),
      .WeN    (ram_we_n_s),
      .WrAddr (wr_ptr_q),
      .WrData (Data_In),
      .RdAddr (rd_ptr_q),
      .RdData (ram_rd_s)
   );

   // Next-state: pointers, count, flags from next count, sticky errors.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      full_n_d   = full_n_q;
      empty_n_d  = empty_n_q;
      afull_n_d  = afull_n_q;
      aempty_n_d = aempty_n_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      dout_d     = dout_q;
      if (!ClrN) begin
         // Clear lands on the reset values; the output register holds.
         wr_ptr_d   = {AWIDTH{1'b0}};
         rd_ptr_d   = {AWIDTH{1'b0}};
         count_d    = {CW{1'b0}};
         full_n_d   = 1'b1;
         empty_n_d  = 1'b0;
         afull_n_d  = 1'b1;
         aempty_n_d = 1'b0;
         ovf_d      = 1'b0;
         udf_d      = 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = ram_rd_s;
         end else begin
            rd_ptr_d = rd_ptr_q;
            dout_d   = dout_q;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         // Flags follow next-count so they never lag Count.
         full_n_d   = (count_d != DEPTH_C);
         empty_n_d  = (count_d != {CW{1'b0}});
         afull_n_d  = ~(count_d >= AFullThr);
         aempty_n_d = ~(count_d <= AEmptyThr);
         ovf_d      = ovf_q | (~WrN & ~wr_acc_s);
         udf_d      = udf_q | (~RdN & ~rd_acc_s);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         wr_ptr_q   <= {AWIDTH{1'b0}};
         rd_ptr_q   <= {AWIDTH{1'b0}};
         count_q    <= {CW{1'b0}};
         full_n_q   <= 1'b1;
         empty_n_q  <= 1'b0;
         afull_n_q  <= 1'b1;
         aempty_n_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         dout_q     <= {DWIDTH{1'b0}};
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_n_q   <= full_n_d;
         empty_n_q  <= empty_n_d;
         afull_n_q  <= afull_n_d;
         aempty_n_q <= aempty_n_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         dout_q     <= dout_d;
      end
   end

   // Show-ahead presents the head word straight from the array.
   assign Data_Out = FWFT ? ram_rd_s : dout_q;
   assign Count    = count_q;
   assign FullN    = full_n_q;
   assign EmptyN   = empty_n_q;
   assign AFullN   = afull_n_q;
   assign AEmptyN  = aempty_n_q;
   assign Ovf      = ovf_q;
   assign Udf      = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (DWIDTH=8, DEPTH=4). Instance u_dut
// runs show-ahead; u_reg shares the same inputs and runs registered-read.
module tb_fifo_sync_param;

   logic       Clk = 1'b0;
   logic       RstN, ClrN, WrN, RdN;
   logic [7:0] Data_In;
   logic [2:0] AFullThr, AEmptyThr;
   logic [7:0] dout_s, dout2_s;
   logic [2:0] count_s, count2_s;
   logic       full_n_s, empty_n_s, afull_n_s, aempty_n_s, ovf_s, udf_s;
   logic       full2_s, empty2_s, afull2_s, aempty2_s, ovf2_s, udf2_s;

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   fifo_sync_param #(.DWIDTH(8), .DEPTH(4), .FWFT(1'b1)) u_dut (
      .Clk(Clk), .RstN(RstN), .ClrN(ClrN), .WrN(WrN), .Data_In(Data_In),
      .RdN(RdN), .AFullThr(AFullThr), .AEmptyThr(AEmptyThr),
      .Data_Out(dout_s), .Count(count_s), .FullN(full_n_s),
      .EmptyN(empty_n_s), .AFullN(afull_n_s), .AEmptyN(aempty_n_s),
      .Ovf(ovf_s), .Udf(udf_s));

   fifo_sync_param #(.DWIDTH(8), .DEPTH(4), .FWFT(1'b0)) u_reg (
      .Clk(Clk), .RstN(RstN), .ClrN(ClrN), .WrN(WrN), .Data_In(Data_In),
      .RdN(RdN), .AFullThr(AFullThr), .AEmptyThr(AEmptyThr),
      .Data_Out(dout2_s), .Count(count2_s), .FullN(full2_s),
      .EmptyN(empty2_s), .AFullN(afull2_s), .AEmptyN(aempty2_s),
      .Ovf(ovf2_s), .Udf(udf2_s));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given requests; returns #1 after the edge, idle.
   task automatic cyc(input logic wn, input logic [7:0] d, input logic rn);
      WrN = wn; Data_In = d; RdN = rn;
      @(posedge Clk); #1;
      WrN = 1'b1; RdN = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"},   32'(count_s),    32'd0);
      chk({tag, "_fulln"},   32'(full_n_s),   32'd1);
      chk({tag, "_emptyn"},  32'(empty_n_s),  32'd0);
      chk({tag, "_afulln"},  32'(afull_n_s),  32'd1);
      chk({tag, "_aemptyn"}, 32'(aempty_n_s), 32'd0);
      chk({tag, "_ovf"},     32'(ovf_s),      32'd0);
      chk({tag, "_udf"},     32'(udf_s),      32'd0);
      chk({tag, "_dout2"},   32'(dout2_s),    32'd0);
   endtask

   initial begin
      RstN = 1'b1; ClrN = 1'b1; WrN = 1'b1; RdN = 1'b1; Data_In = 8'h00;
      AFullThr = 3'd3; AEmptyThr = 3'd1;
      #1 RstN = 1'b0;
      #1 chk_reset_vals("rst");
      @(posedge Clk); #1 RstN = 1'b1;
      @(posedge Clk); #1;

      // Fill with thresholds AFull=3, AEmpty=1
      cyc(1'b0, 8'h11, 1'b1);
      chk("f1_count", 32'(count_s), 32'd1);
      chk("f1_emptyn", 32'(empty_n_s), 32'd1);
      chk("f1_aemptyn", 32'(aempty_n_s), 32'd0);
      chk("f1_dout", 32'(dout_s), 32'h11);
      cyc(1'b0, 8'h22, 1'b1);
      chk("f2_count", 32'(count_s), 32'd2);
      chk("f2_aemptyn", 32'(aempty_n_s), 32'd1);
      chk("f2_afulln", 32'(afull_n_s), 32'd1);
      cyc(1'b0, 8'h33, 1'b1);
      chk("f3_count", 32'(count_s), 32'd3);
      chk("f3_afulln", 32'(afull_n_s), 32'd0);
      chk("f3_fulln", 32'(full_n_s), 32'd1);
      cyc(1'b0, 8'h44, 1'b1);
      chk("f4_count", 32'(count_s), 32'd4);
      chk("f4_fulln", 32'(full_n_s), 32'd0);
      chk("f4_afulln", 32'(afull_n_s), 32'd0);

      // Overflow: rejected write changes nothing but Ovf
      cyc(1'b0, 8'h77, 1'b1);
      chk("ovf_flag", 32'(ovf_s), 32'd1);
      chk("ovf_count", 32'(count_s), 32'd4);
      chk("ovf_head", 32'(dout_s), 32'h11);
      chk("ovf_udf", 32'(udf_s), 32'd0);

      // Simultaneous read+write when full
      cyc(1'b0, 8'h55, 1'b0);
      chk("simf_count", 32'(count_s), 32'd4);
      chk("simf_fulln", 32'(full_n_s), 32'd0);

      // Drain: 22, 33, 44, 55
      chk("d1_dout", 32'(dout_s), 32'h22);
      cyc(1'b1, 8'h00, 1'b0);
      chk("d1_count", 32'(count_s), 32'd3);
      chk("d1_fulln", 32'(full_n_s), 32'd1);
      chk("d2_dout", 32'(dout_s), 32'h33);
      cyc(1'b1, 8'h00, 1'b0);
      chk("d2_count", 32'(count_s), 32'd2);
      chk("d3_dout", 32'(dout_s), 32'h44);
      cyc(1'b1, 8'h00, 1'b0);
      chk("d3_count", 32'(count_s), 32'd1);
      chk("d3_aemptyn", 32'(aempty_n_s), 32'd0);
      chk("d4_dout", 32'(dout_s), 32'h55);
      cyc(1'b1, 8'h00, 1'b0);
      chk("d4_count", 32'(count_s), 32'd0);
      chk("d4_emptyn", 32'(empty_n_s), 32'd0);
      chk("d4_aemptyn", 32'(aempty_n_s), 32'd0);

      // Underflow
      cyc(1'b1, 8'h00, 1'b0);
      chk("udf_flag", 32'(udf_s), 32'd1);
      chk("udf_count", 32'(count_s), 32'd0);
      chk("udf_ovf_held", 32'(ovf_s), 32'd1);

      // Simultaneous read+write when empty
      cyc(1'b0, 8'h66, 1'b0);
      chk("sime_count", 32'(count_s), 32'd1);
      chk("sime_udf", 32'(udf_s), 32'd1);
      chk("sime_dout", 32'(dout_s), 32'h66);

      // Clear together with a write: nothing lands
      ClrN = 1'b0;
      cyc(1'b0, 8'h99, 1'b1);
      ClrN = 1'b1;
      chk("clr_count", 32'(count_s), 32'd0);
      chk("clr_ovf", 32'(ovf_s), 32'd0);
      chk("clr_udf", 32'(udf_s), 32'd0);
      chk("clr_emptyn", 32'(empty_n_s), 32'd0);
      chk("clr_dout2_hold", 32'(dout2_s), 32'h55);
      cyc(1'b0, 8'hAB, 1'b1);
      chk("pclr_count", 32'(count_s), 32'd1);
      chk("pclr_dout", 32'(dout_s), 32'hAB);

      // Threshold change while Count is static
      cyc(1'b0, 8'hC1, 1'b1);
      cyc(1'b0, 8'hC2, 1'b1);
      chk("thr_count", 32'(count_s), 32'd3);
      chk("thr_afulln_lo", 32'(afull_n_s), 32'd0);
      AFullThr = 3'd4;
      cyc(1'b1, 8'h00, 1'b1);
      chk("thr_afulln_hi", 32'(afull_n_s), 32'd1);
      chk("thr_count_static", 32'(count_s), 32'd3);
      chk("thr_r1", 32'(dout_s), 32'hAB);
      cyc(1'b1, 8'h00, 1'b0);
      chk("thr_r2", 32'(dout_s), 32'hC1);
      cyc(1'b1, 8'h00, 1'b0);
      chk("thr_r3", 32'(dout_s), 32'hC2);
      cyc(1'b1, 8'h00, 1'b0);
      chk("thr_empty", 32'(count_s), 32'd0);

      // Ten write/read pairs across the pointer wrap
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 8'h30 + 8'(i), 1'b1);
         chk($sformatf("wrap_dout%0d", i), 32'(dout_s), 32'h30 + 32'(i));
         cyc(1'b1, 8'h00, 1'b0);
         chk($sformatf("wrap_cnt%0d", i), 32'(count_s), 32'd0);
      end

      // Registered-read instance
      cyc(1'b0, 8'hA5, 1'b1);
      chk("reg_hold_pre", 32'(dout2_s), 32'h39);
      cyc(1'b1, 8'h00, 1'b0);
      chk("reg_load", 32'(dout2_s), 32'hA5);
      cyc(1'b1, 8'h00, 1'b1);
      chk("reg_hold", 32'(dout2_s), 32'hA5);

      // Asynchronous reset mid-burst
      cyc(1'b0, 8'hE0, 1'b1);
      WrN = 1'b0; Data_In = 8'hE1;
      @(posedge Clk); #1;
      chk("burst_count", 32'(count_s), 32'd2);
      #2 RstN = 1'b0;
      #1 chk_reset_vals("midrst");
      WrN = 1'b1;
      @(negedge Clk) RstN = 1'b1;
      @(posedge Clk); #1;
      chk("postrst_count", 32'(count_s), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Bound on total runtime.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's fixed 32x4 FIFO.
- Generalised data width and depth.
- Adds: occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, selectable show-ahead (FWFT) or registered-read output.
- Sits between producer/consumer blocks in the datapath; all status flags are registered and coherent with Count.

Parameters:
- DWIDTH, 32, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AWIDTH, $clog2(DEPTH), pointer width; derived, never overridden.
- FWFT, 1, 1 = show-ahead output, 0 = registered read with 1-cycle latency.

Ports:
- Clk  input  1  clock, rising edge.
- RstN  input  1  asynchronous active-low reset.
- ClrN  input  1  synchronous active-low clear.
- WrN  input  1  active-low write request.
- Data_In  input  DWIDTH  write data.
- RdN  input  1  active-low read request.
- AFullThr  input  AWIDTH+1  almost-full threshold.
- AEmptyThr  input  AWIDTH+1  almost-empty threshold.
- Data_Out  output  DWIDTH  read data.
- Count  output  AWIDTH+1  current occupancy, 0..DEPTH.
- FullN  output  1  low when Count==DEPTH.
- EmptyN  output  1  low when Count==0.
- AFullN  output  1  low when Count>=AFullThr.
- AEmptyN  output  1  low when Count<=AEmptyThr.
- Ovf  output  1  sticky overflow, active high.
- Udf  output  1  sticky underflow, active high.

Behaviour:
- Reset (RstN=0, async): wr_ptr=0, rd_ptr=0, Count=0, FullN=1, EmptyN=0, AFullN=1, AEmptyN=0 (per Count=0; thresholds re-evaluated from first clock), Ovf=0, Udf=0. Data_Out=0 when FWFT=0. Storage array is not reset.
- ClrN=0 at a clock edge:
  - Same register values as reset.
  - Overrides WrN/RdN in that cycle; no write lands, no read occurs.
- Acceptance, evaluated on current registered state:
  - rd_acc = ~RdN & (Count!=0).
  - wr_acc = ~WrN & ((Count!=DEPTH) | rd_acc).
  - Full with simultaneous read+write: both accepted, Count unchanged.
  - Empty with simultaneous read+write: read rejected (Udf set), write accepted, Count becomes 1.
- Pointer update:
  - wr_acc writes Data_In at wr_ptr, then wr_ptr+1.
  - rd_acc advances rd_ptr+1.
  - Pointers wrap modulo DEPTH naturally (AWIDTH bits).
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Never leaves 0..DEPTH.
- Flag timing:
  - FullN, EmptyN, AFullN and AEmptyN are registered, computed from next-Count.
  - They change in the same cycle Count changes; no flag lags Count.
  - Thresholds are sampled every cycle; a threshold change takes effect on the next edge even when Count is static.
- Threshold limits:
  - AFullThr=0 forces AFullN=0 permanently.
  - AEmptyThr>=DEPTH forces AEmptyN=0 permanently.
  - No clamping is applied.
- Errors:
  - Ovf sets when ~WrN & ~wr_acc.
  - Udf sets when ~RdN & ~rd_acc.
  - Both hold until ClrN or RstN.
  - A rejected access changes no other state.
- FWFT=1:
  - Data_Out = mem[rd_ptr], combinational from the array.
  - Valid whenever EmptyN=1; don't-care when empty.
  - Zero read latency; the word presented is the one consumed on rd_acc.
- FWFT=0:
  - Data_Out is registered; loads mem[rd_ptr] on rd_acc and is valid the cycle after.
  - Holds its value otherwise, including across ClrN.
- Write-to-read visibility: a word written at edge N is readable (EmptyN=1, FWFT data valid) after edge N. There is no same-cycle bypass.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously. Deassertion is synchronised externally.

Decomposition:
- Package fifo_pkg:
  - default DWIDTH/DEPTH constants.
  - clog2 function.
  - occupancy-count width helper (AWIDTH+1).
- One sub-module, fifo_ram_dp:
  - 1 write port (sync, active-low WrN-driven enable), 1 asynchronous read port.
  - Parameters DWIDTH and DEPTH.
  - Holds the storage array only; no control logic.
- Control, flags and the output register live in fifo_sync_param.

Test Plan (DWIDTH=8, DEPTH=4, FWFT=1 unless stated):
- Fill/drain:
  - Stimulus: write 0x11,0x22,0x33,0x44, then 4 reads.
  - Required: Count 1,2,3,4 then 3..0; FullN=0 exactly at Count=4; reads return 0x11..0x44 in order; EmptyN=0 after the last read.
- Overflow/underflow:
  - Stimulus: 5th write when full; read when empty.
  - Required: contents unchanged; Ovf=1, then Udf=1; both stay 1 until ClrN=0; both return to 0 after the clear.
- Simultaneous access:
  - Stimulus: when full, WrN=RdN=0 with data 0x55.
  - Required: Count stays 4; oldest word read; 0x55 appears as the 4th word out.
  - Stimulus: when empty, WrN=RdN=0 with data 0x66.
  - Required: Count=1; Udf=1; 0x66 is the next word read.
- Thresholds:
  - Stimulus: AFullThr=3, AEmptyThr=1; fill to 4.
  - Required: AEmptyN=0 at Count 0,1; AFullN=0 at Count 3,4.
  - Stimulus: change AFullThr to 4 at Count=3.
  - Required: AFullN=1 on the next edge.
- Wrap/clear/reset:
  - Stimulus: 10 write/read pairs across the pointer wrap.
  - Required: data order preserved.
  - Stimulus: ClrN=0 together with WrN=0.
  - Required: Count=0 and no write lands.
  - Stimulus: RstN pulse mid-burst.
  - Required: all outputs at reset values asynchronously.
- FWFT=0:
  - Stimulus: write 0xA5, then read.
  - Required: Data_Out=0xA5 one cycle after rd_acc; Data_Out holds when RdN=1.
